// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor.
// One combinational full_adder is time-multiplexed across the operand bits,
// LSB first; subtraction is a + ~b + 1 via operand inversion and carry seed.

// Single-bit combinational full adder; the only arithmetic in this block.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry_out
);

    // Sum and majority-carry of the three input bits
    always_comb begin
        sum       = a ^ b ^ c_in;
        carry_out = (a & b) | (a & c_in) | (b & c_in);
    end

endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_co;
    logic [WIDTH-1:0] next_acc;

    full_adder u_fa (
        .a         (opa[0]),
        .b         (opb[0]),
        .c_in      (cy),
        .sum       (fa_sum),
        .carry_out (fa_co)
    );

    // Accumulator after shifting the current sum bit into the MSB
    always_comb begin
        next_acc = {fa_sum, acc[WIDTH-1:1]};
    end

    // Operation sequencer, serial datapath and registered result/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b ^ {WIDTH{sub}};
                        cy    <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= next_acc;
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    cy  <= fa_co;
                    if (cnt == LAST) begin
                        // cy still holds the carry into the MSB at this edge
                        result    <= next_acc;
                        carry_out <= fa_co;
                        overflow  <= cy ^ fa_co;
                        zero      <= (next_acc == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub (WIDTH = 8).
module tb_serial_add_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       overflow;

    int passed;
    int total;

    serial_add_sub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Present an operation now, clock it in, then wait (bounded) for done.
    // Returns edges after the start edge until done, and busy-high samples.
    task automatic do_op(input logic [7:0] opa, input logic [7:0] opb, input logic s,
                         output int cycles, output int nbusy);
        a = opa; b = opb; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        nbusy  = 0;
        if (busy) nbusy++;
        while (!done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (busy) nbusy++;
            if (busy && done) chk("busy_done_overlap", 1, 0);
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] r, input logic c,
                           input logic z, input logic v);
        chk({tag, "_result"},   result,    r);
        chk({tag, "_carry"},    carry_out, c);
        chk({tag, "_zero"},     zero,      z);
        chk({tag, "_overflow"}, overflow,  v);
    endtask

    initial begin
        int cyc;
        int nb;
        int ndone;
        passed = 0;
        total  = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk_res("reset", 8'h00, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // 25 + 1A: latency and busy width
        do_op(8'h25, 8'h1A, 1'b0, cyc, nb);
        chk("add1_latency", cyc, 8);
        chk("add1_busy_cycles", nb, 8);
        chk("add1_done", done, 1);
        chk_res("add1", 8'h3F, 0, 0, 0);
        @(posedge clk); #1;
        chk("add1_done_pulse_end", done, 0);
        chk("add1_idle_busy", busy, 0);

        // FF + 01: wrap to zero with carry
        do_op(8'hFF, 8'h01, 1'b0, cyc, nb);
        chk("add2_latency", cyc, 8);
        chk_res("add2", 8'h00, 1, 1, 0);
        @(posedge clk); #1;

        // 7F + 01: signed overflow
        do_op(8'h7F, 8'h01, 1'b0, cyc, nb);
        chk("add3_latency", cyc, 8);
        chk_res("add3", 8'h80, 0, 0, 1);
        @(posedge clk); #1;

        // 05 - 07: borrow
        do_op(8'h05, 8'h07, 1'b1, cyc, nb);
        chk("sub1_latency", cyc, 8);
        chk_res("sub1", 8'hFE, 0, 0, 0);
        // back-to-back start while in DONE: 80 - 01
        do_op(8'h80, 8'h01, 1'b1, cyc, nb);
        chk("sub2_latency", cyc, 8);
        chk("sub2_busy_cycles", nb, 8);
        chk_res("sub2", 8'h7F, 1, 0, 1);
        @(posedge clk); #1;

        // start during RUN is ignored
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (done) ndone++;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (done) chk_res("ign", 8'h30, 0, 0, 0);
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_idle_busy", busy, 0);

        // asynchronous reset in RUN cycle 4
        a = 8'h25; b = 8'h1A; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_res("rst", 8'h00, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("rst_no_activity", ndone, 0);

        do_op(8'h01, 8'h01, 1'b0, cyc, nb);
        chk("post_rst_latency", cyc, 8);
        chk_res("post_rst", 8'h02, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
